// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_seq
// Purpose  : Sequential signed divider, 32-bit dividend by 16-bit divisor.
//            Restoring division on operand magnitudes, one quotient bit per
//            clock, followed by a sign/exception fix-up cycle. Latency is
//            fixed for every operand pair.
// Ports    : clk    - clock, all state updates on the rising edge
//            reset  - synchronous active-high reset
//            start  - request, sampled only while idle
//            a      - signed dividend (32)
//            b      - signed divisor (16)
//            q      - signed quotient, truncated toward zero (32)
//            r      - signed remainder, sign follows dividend (16)
//            busy   - high from operand capture until the result is written
//            done   - one-cycle pulse marking q/r/dz/ovf valid
//            dz     - divide-by-zero flag
//            ovf    - quotient overflow flag (-2^31 / -1)
// Revision : 1.0 - initial release
// ============================================================================
module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [15:0] b,
    output logic [31:0] q,
    output logic [15:0] r,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic        ovf
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    localparam logic [4:0] c_LAST_STEP = 5'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;

    // r_dvd holds |a| at capture; quotient bits shift in at the bottom as the
    // dividend bits leave from the top, so it ends up holding |q|.
    logic [31:0] r_dvd;
    // |b| never exceeds 2^15, so 16 unsigned bits hold it exactly.
    logic [15:0] r_div;
    // Stored partial remainder is always < |b|, so 16 bits suffice; the
    // 17-bit partial remainder exists only after the shift (w_shift).
    logic [15:0] r_prem;
    logic [4:0]  r_count;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_dz_pend;
    logic        r_ovf_pend;

    logic [31:0] w_abs_a;
    logic [15:0] w_abs_b;
    logic [16:0] w_shift;
    logic        w_ge;
    logic [15:0] w_diff;

    // Two's-complement negate of the most negative value yields the same bit
    // pattern, which reads correctly as an unsigned magnitude.
    assign w_abs_a = a[31] ? (32'd0 - a) : a;
    assign w_abs_b = b[15] ? (16'd0 - b) : b;

    assign w_shift = {r_prem, r_dvd[31]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    // When the trial succeeds the true difference is < |b| <= 2^15, so a
    // 16-bit modular subtraction is exact.
    assign w_diff  = w_shift[15:0] - r_div;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_next = c_ST_RUN;
            c_ST_RUN:  if (r_count == c_LAST_STEP) w_state_next = c_ST_FIX;
            c_ST_FIX:  w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dvd      <= 32'd0;
            r_div      <= 16'd0;
            r_prem     <= 16'd0;
            r_count    <= 5'd0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_dz_pend  <= 1'b0;
            r_ovf_pend <= 1'b0;
            q          <= 32'd0;
            r          <= 16'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dz         <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_dvd      <= w_abs_a;
                        r_div      <= w_abs_b;
                        r_prem     <= 16'd0;
                        r_count    <= 5'd0;
                        r_sign_q   <= a[31] ^ b[15];
                        r_sign_r   <= a[31];
                        r_dz_pend  <= (b == 16'd0);
                        r_ovf_pend <= (a == 32'h8000_0000) && (b == 16'hFFFF);
                        busy       <= 1'b1;
                    end
                end
                c_ST_RUN: begin
                    r_prem  <= w_ge ? w_diff : w_shift[15:0];
                    r_dvd   <= {r_dvd[30:0], w_ge};
                    r_count <= r_count + 5'd1;
                end
                c_ST_FIX: begin
                    if (r_dz_pend) begin
                        q <= r_sign_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        r <= 16'd0;
                    end else if (r_ovf_pend) begin
                        q <= 32'h7FFF_FFFF;
                        r <= 16'd0;
                    end else begin
                        q <= r_sign_q ? (32'd0 - r_dvd) : r_dvd;
                        r <= r_sign_r ? (16'd0 - r_prem) : r_prem;
                    end
                    dz   <= r_dz_pend;
                    ovf  <= r_ovf_pend;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
